pn_state_monitor: RTL and testbench
===================================

PN_STATE_MONITOR -- requirements
Module: pn_state_monitor

Interface
REQ-001 Parameter LOCK_LEN, default 4, number of consecutive correct transitions required to lock (legal range 1..15).
REQ-002 Clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 en  input  1  sample strobe; state_in is sampled only when en=1.
REQ-005 state_in  input  2  {FA,FB} state word from the upstream PN-flip-flop counter.
REQ-006 clr_err  input  1  synchronous clear of err_flag and err_cnt.
REQ-007 locked  output  1  high while the FSM is in LOCKED.
REQ-008 err_pulse  output  1  one-cycle pulse on an illegal transition while LOCKED.
REQ-009 err_flag  output  1  sticky error indicator.
REQ-010 err_cnt  output  8  saturating count of illegal transitions seen while LOCKED.
REQ-011 cycle_pulse  output  1  one-cycle pulse on completion of a full sequence while LOCKED.
REQ-012 cycle_cnt  output  8  wrapping count of completed sequences.
REQ-013 exp_state  output  2  expected next state_in, valid while locked=1, 00 otherwise.
REQ-014 dec  output  4  registered one-hot decode of the last sampled state; dec[i]=1 iff the state equals i.

Function
REQ-015 Legal successor function next(s): 00->11, 11->01, 01->10, 10->00.
REQ-016 Registers: prev[1:0], prev_valid, good_cnt[3:0], FSM state; all outputs are registered.
REQ-017 Output latency: each output reflects the sample taken at the preceding rising edge with en=1.
REQ-018 en=0: every register holds; err_pulse and cycle_pulse are 0; clr_err still acts.
REQ-019 Sample with en=1: prev<=state_in, prev_valid<=1, dec<=onehot(state_in).
REQ-020 A transition is good iff prev_valid=1 and state_in==next(prev); a repeated state (state_in==prev) is bad.
REQ-021 FSM states: IDLE, TRACK, LOCKED.
REQ-022 IDLE: the first sample moves to TRACK with good_cnt=0; no transition is evaluated.
REQ-023 TRACK good transition: good_cnt++; when the incremented value equals LOCK_LEN, go to LOCKED and clear good_cnt.
REQ-024 TRACK bad transition: good_cnt<=0, stay in TRACK, no error reported.
REQ-025 LOCKED good transition: stay in LOCKED; exp_state<=next(state_in).
REQ-026 LOCKED bad transition: err_pulse=1, err_flag<=1, err_cnt++ (saturating at 255), go to TRACK with good_cnt=0, locked<=0.
REQ-027 cycle_pulse=1 and cycle_cnt++ (wrapping 255->0) only when the FSM is LOCKED before the edge and the good transition is 10->00.
REQ-028 The transition that enters LOCKED does not generate cycle_pulse.
REQ-029 On entering LOCKED, exp_state<=next(state_in).
REQ-030 clr_err=1 clears err_flag and err_cnt to 0.
REQ-031 If clr_err and an error occur in the same cycle, the result is err_cnt=1 and err_flag=1, with err_pulse=1.
REQ-032 cycle_cnt is cleared only by rst.

Reset
REQ-033 While rst=1: FSM=IDLE, prev=00, prev_valid=0, good_cnt=0, and every output is 0.
REQ-034 rst asserted mid-sequence or while LOCKED returns the block to the REQ-033 state immediately, without waiting for Clk.
REQ-035 After rst deasserts, the block requires 1 + LOCK_LEN samples to lock.

Verification
REQ-036 rst pulse, then en=1 with the sequence 00,11,01,10,00 (LOCK_LEN=4) -> locked=1 after the 5th sample, exp_state=11, cycle_pulse=0.
REQ-037 Locked, continue 11,01,10,00 -> exactly one cycle_pulse on the 10->00 sample; cycle_cnt=1.
REQ-038 Locked at state 11, then inject 10 -> err_pulse=1 for one cycle, err_flag=1, err_cnt=1, locked=0; relock after 4 further good transitions.
REQ-039 Hold en=0 for 10 cycles mid-sequence while state_in toggles randomly -> no output changes and no errors.
REQ-040 Force 256 lock/error cycles -> err_cnt stays at 255; clr_err coincident with an error -> err_cnt=1.
REQ-041 Assert rst asynchronously between Clk edges while locked -> all outputs 0 before the next edge; repeated state 00,00 in TRACK -> good_cnt=0, no err_pulse.

Source files
------------

// File: rtl/pn_state_monitor.sv
// pn_state_monitor
//   Watches the 2-bit {FA,FB} state word of an upstream PN flip-flop counter
//   and checks that it steps through the legal ring 00 -> 11 -> 01 -> 10 -> 00.
//   After LOCK_LEN consecutive legal transitions the monitor locks; while
//   locked, every illegal transition is reported as an error and drops lock,
//   and every completed ring (the 10 -> 00 step) is counted.
//
// Ports
//   Clk          clock, all state updates on the rising edge
//   rst          asynchronous, active-high reset
//   en           sample strobe; state_in is only looked at when en=1
//   state_in     {FA,FB} state word
//   clr_err      synchronous clear of err_flag / err_cnt (acts even when en=0)
//   locked       high while the monitor is locked
//   err_pulse    one-cycle pulse on an illegal transition while locked
//   err_flag     sticky error flag
//   err_cnt      saturating count of illegal transitions while locked
//   cycle_pulse  one-cycle pulse when a full ring completes while locked
//   cycle_cnt    wrapping count of completed rings (cleared only by rst)
//   exp_state    expected next state_in while locked, 00 otherwise
//   dec          one-hot decode of the last sampled state
module pn_state_monitor #(
  parameter int LOCK_LEN = 4
) (
  input  logic       Clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] state_in,
  input  logic       clr_err,
  output logic       locked,
  output logic       err_pulse,
  output logic       err_flag,
  output logic [7:0] err_cnt,
  output logic       cycle_pulse,
  output logic [7:0] cycle_cnt,
  output logic [1:0] exp_state,
  output logic [3:0] dec
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_LEN_C = 4'(LOCK_LEN);

  // Legal successor in the PN ring.
  function automatic logic [1:0] next_state(input logic [1:0] s);
    logic [1:0] n;
    case (s)
      2'b00:   n = 2'b11;
      2'b11:   n = 2'b01;
      2'b01:   n = 2'b10;
      default: n = 2'b00;
    endcase
    return n;
  endfunction

  state_t     fsm_q, fsm_d;
  logic [1:0] prev_q, prev_d;
  logic       prev_valid_q, prev_valid_d;
  logic [3:0] good_cnt_q, good_cnt_d;
  logic       locked_q, locked_d;
  logic       err_pulse_q, err_pulse_d;
  logic       err_flag_q, err_flag_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       cycle_pulse_q, cycle_pulse_d;
  logic [7:0] cycle_cnt_q, cycle_cnt_d;
  logic [1:0] exp_state_q, exp_state_d;
  logic [3:0] dec_q, dec_d;

  logic [3:0] dec_onehot;
  logic       good_trans;
  logic [3:0] good_inc;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dec
    assign dec_onehot[gi] = (state_in == 2'(gi));
  end

  assign good_trans = prev_valid_q && (state_in == next_state(prev_q));
  assign good_inc   = good_cnt_q + 4'd1;

  always_comb begin
    fsm_d         = fsm_q;
    prev_d        = prev_q;
    prev_valid_d  = prev_valid_q;
    good_cnt_d    = good_cnt_q;
    locked_d      = locked_q;
    err_pulse_d   = 1'b0;
    err_flag_d    = err_flag_q;
    err_cnt_d     = err_cnt_q;
    cycle_pulse_d = 1'b0;
    cycle_cnt_d   = cycle_cnt_q;
    exp_state_d   = exp_state_q;
    dec_d         = dec_q;

    // Clear first so that an error in the same cycle lands on top of it
    // and leaves err_cnt=1.
    if (clr_err) begin
      err_flag_d = 1'b0;
      err_cnt_d  = 8'd0;
    end

    if (en) begin
      prev_d       = state_in;
      prev_valid_d = 1'b1;
      dec_d        = dec_onehot;

      case (fsm_q)
        ST_IDLE: begin
          // First sample only seeds prev; there is no transition yet.
          fsm_d      = ST_TRACK;
          good_cnt_d = 4'd0;
        end

        ST_TRACK: begin
          if (good_trans) begin
            if (good_inc == LOCK_LEN_C) begin
              fsm_d       = ST_LOCKED;
              good_cnt_d  = 4'd0;
              locked_d    = 1'b1;
              exp_state_d = next_state(state_in);
            end else begin
              good_cnt_d = good_inc;
            end
          end else begin
            good_cnt_d = 4'd0;
          end
        end

        ST_LOCKED: begin
          if (good_trans) begin
            exp_state_d = next_state(state_in);
            // A good transition landing on 00 can only have come from 10,
            // which closes one full ring.
            if (state_in == 2'b00) begin
              cycle_pulse_d = 1'b1;
              cycle_cnt_d   = cycle_cnt_q + 8'd1;
            end
          end else begin
            err_pulse_d = 1'b1;
            err_flag_d  = 1'b1;
            if (err_cnt_d != 8'hFF) begin
              err_cnt_d = err_cnt_d + 8'd1;
            end
            fsm_d       = ST_TRACK;
            good_cnt_d  = 4'd0;
            locked_d    = 1'b0;
            exp_state_d = 2'b00;
          end
        end

        default: begin
          fsm_d      = ST_IDLE;
          good_cnt_d = 4'd0;
          locked_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      fsm_q         <= ST_IDLE;
      prev_q        <= 2'b00;
      prev_valid_q  <= 1'b0;
      good_cnt_q    <= 4'd0;
      locked_q      <= 1'b0;
      err_pulse_q   <= 1'b0;
      err_flag_q    <= 1'b0;
      err_cnt_q     <= 8'd0;
      cycle_pulse_q <= 1'b0;
      cycle_cnt_q   <= 8'd0;
      exp_state_q   <= 2'b00;
      dec_q         <= 4'd0;
    end else begin
      fsm_q         <= fsm_d;
      prev_q        <= prev_d;
      prev_valid_q  <= prev_valid_d;
      good_cnt_q    <= good_cnt_d;
      locked_q      <= locked_d;
      err_pulse_q   <= err_pulse_d;
      err_flag_q    <= err_flag_d;
      err_cnt_q     <= err_cnt_d;
      cycle_pulse_q <= cycle_pulse_d;
      cycle_cnt_q   <= cycle_cnt_d;
      exp_state_q   <= exp_state_d;
      dec_q         <= dec_d;
    end
  end

  assign locked      = locked_q;
  assign err_pulse   = err_pulse_q;
  assign err_flag    = err_flag_q;
  assign err_cnt     = err_cnt_q;
  assign cycle_pulse = cycle_pulse_q;
  assign cycle_cnt   = cycle_cnt_q;
  assign exp_state   = exp_state_q;
  assign dec         = dec_q;

endmodule

// File: tb/tb_pn_state_monitor.sv
// Testbench for pn_state_monitor: directed sample sequences, a ring-position
// reference model compared on every falling edge, and literal expectations
// at the key points of each scenario.
module tb_pn_state_monitor;

  localparam int LOCK_LEN = 4;

  logic       Clk;
  logic       rst;
  logic       en;
  logic [1:0] state_in;
  logic       clr_err;
  logic       locked;
  logic       err_pulse;
  logic       err_flag;
  logic [7:0] err_cnt;
  logic       cycle_pulse;
  logic [7:0] cycle_cnt;
  logic [1:0] exp_state;
  logic [3:0] dec;

  int checks = 0;
  int passed = 0;

  pn_state_monitor #(.LOCK_LEN(LOCK_LEN)) dut (
    .Clk(Clk), .rst(rst), .en(en), .state_in(state_in), .clr_err(clr_err),
    .locked(locked), .err_pulse(err_pulse), .err_flag(err_flag),
    .err_cnt(err_cnt), .cycle_pulse(cycle_pulse), .cycle_cnt(cycle_cnt),
    .exp_state(exp_state), .dec(dec)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
  endtask

  // ---------------- reference model ----------------
  // The legal ring as a list; a transition is good when the new state sits
  // one position further round the ring than the previous one.
  logic [1:0] ring [4];
  initial begin
    ring[0] = 2'b00; ring[1] = 2'b11; ring[2] = 2'b01; ring[3] = 2'b10;
  end

  function automatic int pos_of(input logic [1:0] s);
    for (int i = 0; i < 4; i++) if (ring[i] == s) return i;
    return 0;
  endfunction

  bit         m_have_prev;
  logic [1:0] m_prev;
  int         m_streak;
  bit         m_locked;
  logic [1:0] m_exp;
  logic [3:0] m_dec;
  bit         m_errp, m_errf, m_cycp;
  int         m_errc, m_cycc;

  always @(posedge Clk or posedge rst) begin
    if (rst) begin
      m_have_prev = 0; m_prev = 2'b00; m_streak = 0; m_locked = 0;
      m_exp = 2'b00; m_dec = 4'd0; m_errp = 0; m_errf = 0; m_cycp = 0;
      m_errc = 0; m_cycc = 0;
    end else begin
      bit good;
      m_errp = 0;
      m_cycp = 0;
      if (clr_err) begin
        m_errf = 0;
        m_errc = 0;
      end
      if (en) begin
        if (m_have_prev) begin
          good = (pos_of(state_in) == (pos_of(m_prev) + 1) % 4);
          if (m_locked) begin
            if (good) begin
              m_exp = ring[(pos_of(state_in) + 1) % 4];
              if (pos_of(state_in) == 0) begin
                m_cycp = 1;
                m_cycc = (m_cycc + 1) % 256;
              end
            end else begin
              m_errp = 1;
              m_errf = 1;
              m_errc = (m_errc < 255) ? m_errc + 1 : 255;
              m_locked = 0;
              m_streak = 0;
              m_exp = 2'b00;
            end
          end else if (good) begin
            m_streak++;
            if (m_streak == LOCK_LEN) begin
              m_locked = 1;
              m_streak = 0;
              m_exp = ring[(pos_of(state_in) + 1) % 4];
            end
          end else begin
            m_streak = 0;
          end
        end
        m_have_prev = 1;
        m_prev = state_in;
        m_dec = 4'b0001 << state_in;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    chk("locked", 32'(locked), 32'(m_locked));
    chk("err_pulse", 32'(err_pulse), 32'(m_errp));
    chk("err_flag", 32'(err_flag), 32'(m_errf));
    chk("err_cnt", 32'(err_cnt), 32'(m_errc));
    chk("cycle_pulse", 32'(cycle_pulse), 32'(m_cycp));
    chk("cycle_cnt", 32'(cycle_cnt), 32'(m_cycc));
    chk("exp_state", 32'(exp_state), 32'(m_exp));
    chk("dec", 32'(dec), 32'(m_dec));
  end

  // ---------------- stimulus ----------------
  task automatic samp(input logic [1:0] s, input logic c);
    state_in = s;
    en       = 1'b1;
    clr_err  = c;
    @(posedge Clk);
    #1;
    en      = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_err_pulse"}, 32'(err_pulse), 0);
    chk({tag, "_err_flag"}, 32'(err_flag), 0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 0);
    chk({tag, "_cycle_pulse"}, 32'(cycle_pulse), 0);
    chk({tag, "_cycle_cnt"}, 32'(cycle_cnt), 0);
    chk({tag, "_exp_state"}, 32'(exp_state), 0);
    chk({tag, "_dec"}, 32'(dec), 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; state_in = 2'b00; clr_err = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    idle_cycle();

    // Acquire lock: one seed sample plus LOCK_LEN good transitions.
    samp(2'b00, 0);
    chk("acq_seed_locked", 32'(locked), 0);
    chk("acq_seed_dec", 32'(dec), 32'h1);
    samp(2'b11, 0);
    samp(2'b01, 0);
    samp(2'b10, 0);
    chk("acq_pre_locked", 32'(locked), 0);
    samp(2'b00, 0);
    chk("acq_locked", 32'(locked), 1);
    chk("acq_exp", 32'(exp_state), 32'h3);
    chk("acq_no_cycle", 32'(cycle_pulse), 0);

    // One full ring while locked.
    samp(2'b11, 0);
    chk("ring_exp_01", 32'(exp_state), 32'h1);
    chk("ring_no_pulse", 32'(cycle_pulse), 0);
    samp(2'b01, 0);
    samp(2'b10, 0);
    samp(2'b00, 0);
    chk("ring_pulse", 32'(cycle_pulse), 1);
    chk("ring_cnt", 32'(cycle_cnt), 1);
    idle_cycle();
    chk("ring_pulse_once", 32'(cycle_pulse), 0);

    // Illegal transition 11 -> 10 while locked.
    samp(2'b11, 0);
    samp(2'b10, 0);
    chk("err_pulse_hi", 32'(err_pulse), 1);
    chk("err_flag_hi", 32'(err_flag), 1);
    chk("err_cnt_1", 32'(err_cnt), 1);
    chk("err_unlocked", 32'(locked), 0);
    chk("err_exp_zero", 32'(exp_state), 0);
    idle_cycle();
    chk("err_pulse_once", 32'(err_pulse), 0);
    chk("err_flag_sticky", 32'(err_flag), 1);
    samp(2'b00, 0);
    samp(2'b11, 0);
    samp(2'b01, 0);
    chk("relock_pre", 32'(locked), 0);
    samp(2'b10, 0);
    chk("relock", 32'(locked), 1);
    chk("relock_exp", 32'(exp_state), 0);

    // en=0 while state_in wanders: everything holds.
    for (int i = 0; i < 10; i++) begin
      state_in = 2'($urandom_range(0, 3));
      idle_cycle();
    end
    chk("hold_locked", 32'(locked), 1);
    chk("hold_err_cnt", 32'(err_cnt), 1);
    chk("hold_cycle_cnt", 32'(cycle_cnt), 1);
    chk("hold_dec", 32'(dec), 32'h4);

    // clr_err acts without en.
    clr_err = 1'b1;
    idle_cycle();
    clr_err = 1'b0;
    chk("clr_flag", 32'(err_flag), 0);
    chk("clr_cnt", 32'(err_cnt), 0);
    chk("clr_keeps_lock", 32'(locked), 1);

    // 256 lock/error rounds: repeat 10 (error), then relock via the ring.
    for (int r = 0; r < 256; r++) begin
      samp(2'b10, 0);
      samp(2'b00, 0);
      samp(2'b11, 0);
      samp(2'b01, 0);
      samp(2'b10, 0);
    end
    chk("sat_cnt", 32'(err_cnt), 255);
    chk("sat_locked", 32'(locked), 1);
    samp(2'b10, 1);
    chk("clr_err_same_cnt", 32'(err_cnt), 1);
    chk("clr_err_same_flag", 32'(err_flag), 1);
    chk("clr_err_same_pulse", 32'(err_pulse), 1);

    // Relock, complete one more ring, then reset asynchronously.
    samp(2'b00, 0);
    samp(2'b11, 0);
    samp(2'b01, 0);
    samp(2'b10, 0);
    samp(2'b00, 0);
    chk("ring2_cnt", 32'(cycle_cnt), 2);
    samp(2'b11, 0);
    chk("pre_rst_locked", 32'(locked), 1);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    idle_cycle();
    rst = 1'b0;
    idle_cycle();

    // Repeated state in TRACK clears the streak without an error.
    samp(2'b00, 0);
    samp(2'b11, 0);
    samp(2'b01, 0);
    samp(2'b01, 0);
    chk("repeat_no_err", 32'(err_pulse), 0);
    chk("repeat_no_flag", 32'(err_flag), 0);
    samp(2'b10, 0);
    samp(2'b00, 0);
    samp(2'b11, 0);
    chk("repeat_streak_reset", 32'(locked), 0);
    samp(2'b01, 0);
    chk("repeat_relock", 32'(locked), 1);
    chk("repeat_exp", 32'(exp_state), 32'h2);

    idle_cycle();
    idle_cycle();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
